// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs decoded RV32I instruction fields back into a 32-bit instruction word,
// tags each legal word with a running word address and queues the pair in a
// small output FIFO drained over a valid/ready port.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input handshake for the field bundle
//   opcode, rd, rs1,    decoded fields; imm is the sign-extended immediate in
//   rs2, func3, func7,  decoder convention (byte offsets for B/J, upper bits
//   imm                 in imm[31:12] for U)
//   out_valid/out_ready output handshake for the FIFO head
//   out_instr, out_addr encoded word and its address at the FIFO head
//   illegal             one-cycle pulse after an accepted bundle is rejected
//   count               current FIFO occupancy
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [6:0]                           opcode,
    input  logic [4:0]                           rd,
    input  logic [4:0]                           rs1,
    input  logic [4:0]                           rs2,
    input  logic [2:0]                           func3,
    input  logic [6:0]                           func7,
    input  logic [31:0]                          imm,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [31:0]                          out_instr,
    output logic [31:0]                          out_addr,
    output logic                                 illegal,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_SH  = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_BAD = 3'd7
    } fmt_t;

    // Map an opcode (and funct3 for the shift-immediate exception) to a format.
    function automatic fmt_t classify(input logic [6:0] op, input logic [2:0] f3);
        fmt_t f;
        case (op)
            7'b0110011: f = FMT_R;
            7'b0010011: f = ((f3 == 3'b001) || (f3 == 3'b101)) ? FMT_SH : FMT_I;
            7'b0000011,
            7'b1100111,
            7'b1110011: f = FMT_I;
            7'b0100011: f = FMT_S;
            7'b1100011: f = FMT_B;
            7'b0110111,
            7'b0010111: f = FMT_U;
            7'b1101111: f = FMT_J;
            default:    f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Assemble the instruction word for a given format.
    function automatic logic [31:0] pack(
        input fmt_t        f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] im
    );
        logic [31:0] w;
        case (f)
            FMT_R:   w = {f7, s2, s1, f3, d, op};
            FMT_I:   w = {im[11:0], s1, f3, d, op};
            FMT_SH:  w = {f7, im[4:0], s1, f3, d, op};
            FMT_S:   w = {im[11:5], s2, s1, f3, im[4:0], op};
            FMT_B:   w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            FMT_U:   w = {im[31:12], d, op};
            FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], d, op};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    logic [63:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   addr_ctr_r;
    logic          illegal_r;

    fmt_t          fmt_s;
    logic [31:0]   word_s;
    logic          legal_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [63:0]   head_s;

    // Classify and encode the offered bundle; derive handshake events.
    always_comb begin
        fmt_s    = classify(opcode, func3);
        word_s   = pack(fmt_s, opcode, rd, rs1, rs2, func3, func7, imm);
        if (fmt_s == FMT_BAD) begin
            legal_s = 1'b0;
        end else if (((fmt_s == FMT_B) || (fmt_s == FMT_J)) && imm[0]) begin
            // Branch/jump offsets must be halfword aligned.
            legal_s = 1'b0;
        end else begin
            legal_s = 1'b1;
        end
        accept_s = in_valid && in_ready;
        push_s   = accept_s && legal_s;
        pop_s    = out_valid && out_ready;
    end

    // Output view of the registered FIFO state; empty FIFO reads as zero.
    always_comb begin
        head_s    = mem_r[rd_ptr_r];
        out_valid = (count_r != CW'(0));
        // Reset holds in_ready low so nothing is accepted on the reset edge.
        in_ready  = !rst && (count_r != CW'(FIFO_DEPTH));
        count     = count_r;
        illegal   = illegal_r;
        if (out_valid) begin
            out_instr = head_s[63:32];
            out_addr  = head_s[31:0];
        end else begin
            out_instr = 32'h0;
            out_addr  = 32'h0;
        end
    end

    // Pointers, occupancy, address counter and the illegal pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
            addr_ctr_r <= BASE_ADDR;
            illegal_r  <= 1'b0;
        end else begin
            illegal_r <= accept_s && !legal_s;
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + PW'(1);
                addr_ctr_r <= addr_ctr_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the output is gated by count.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= {word_s, addr_ctr_r};
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        illegal;
    logic [2:0]  count;

    instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3),
        .func7(func7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .illegal(illegal), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] w; logic [31:0] a; } ent_t;
    typedef struct {
        logic [6:0] op; logic [4:0] d; logic [4:0] s1; logic [4:0] s2;
        logic [2:0] f3; logic [6:0] f7; logic [31:0] im; logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // reference model state
    ent_t        q[$];
    logic [31:0] m_addr = 32'h0;
    logic        m_illegal = 1'b0;
    int          m_accepted = 0;
    int          acc_base = 0;

    // observations of the DUT ports
    ent_t log_q[$];
    int   dut_acc = 0;
    int   ill_cnt = 0;

    vec_t sv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Encoding straight from the field-placement table, as shifts and masks.
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] d,
            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w, base, rdf;
        logic ok;
        ok   = 1'b1;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        rdf  = 32'(d) << 7;
        case (op)
            7'h33: w = (32'(f7) << 25) | (32'(s2) << 20) | base | rdf;
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5)
                    w = (32'(f7) << 25) | ((im & 32'h1F) << 20) | base | rdf;
                else
                    w = ((im & 32'hFFF) << 20) | base | rdf;
            end
            7'h03, 7'h67, 7'h73: w = ((im & 32'hFFF) << 20) | base | rdf;
            7'h23: w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((im & 32'h1F) << 7);
            7'h63: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) |
                    (32'(s2) << 20) | base | (((im >> 1) & 32'hF) << 8) |
                    (((im >> 11) & 32'h1) << 7);
                ok = ((im & 32'h1) == 32'h0);
            end
            7'h37, 7'h17: w = (im & 32'hFFFFF000) | rdf | 32'(op);
            7'h6F: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
                    (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) |
                    rdf | 32'(op);
                ok = ((im & 32'h1) == 32'h0);
            end
            default: begin
                w  = 32'h0;
                ok = 1'b0;
            end
        endcase
        return {ok, w};
    endfunction

    // Model update at each rising edge from the inputs held across it.
    initial begin
        logic [32:0] r;
        logic acc;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_addr    = 32'h0;
                m_illegal = 1'b0;
            end else begin
                acc = in_valid && (q.size() != 4);
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                m_illegal = 1'b0;
                if (acc) begin
                    m_accepted++;
                    r = model_enc(opcode, rd, rs1, rs2, func3, func7, imm);
                    if (r[32]) begin
                        q.push_back('{w: r[31:0], a: m_addr});
                        m_addr = m_addr + 32'd4;
                    end else begin
                        m_illegal = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", 32'(in_ready), 32'(!rst && q.size() != 4));
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("count", 32'(count), 32'(q.size()));
                chk("illegal", 32'(illegal), 32'(m_illegal));
                if (q.size() != 0) begin
                    chk("out_instr", out_instr, q[0].w);
                    chk("out_addr", out_addr, q[0].a);
                end else begin
                    chk("out_instr_idle", out_instr, 32'h0);
                    chk("out_addr_idle", out_addr, 32'h0);
                end
                if (out_valid && out_ready && !rst) log_q.push_back('{w: out_instr, a: out_addr});
                if (in_valid && in_ready) dut_acc++;
                if (illegal) ill_cnt++;
            end
        end
    end

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
        in_valid = 1'b1;
        acc_base = m_accepted;
    endtask

    task automatic wait_acc();
        int n = 0;
        while (m_accepted == acc_base && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_accepted == acc_base) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no acceptance expected one within 100 cycles");
        end
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        drive(op, d, s1, s2, f3, f7, im);
        wait_acc();
    endtask

    task automatic send_v(input int i);
        send(sv[i].op, sv[i].d, sv[i].s1, sv[i].s2, sv[i].f3, sv[i].f7, sv[i].im);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d entries expected 0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int base, acc0, ill0;
        sv[0] = '{7'h13, 5'd14, 5'd0,  5'd0,  3'd0, 7'd0, 32'h0,        32'h00000713};
        sv[1] = '{7'h13, 5'd12, 5'd0,  5'd0,  3'd0, 7'd0, 32'd10,       32'h00a00613};
        sv[2] = '{7'h13, 5'd13, 5'd0,  5'd0,  3'd0, 7'd0, 32'hFFFFF801, 32'h80100693};
        sv[3] = '{7'h33, 5'd14, 5'd13, 5'd14, 3'd0, 7'd0, 32'h0,        32'h00e68733};
        sv[4] = '{7'h63, 5'd0,  5'd13, 5'd12, 3'd4, 7'd0, 32'hFFFFFFF8, 32'hFEC6CCE3};
        sv[5] = '{7'h13, 5'd30, 5'd14, 5'd0,  3'd0, 7'd0, 32'hFFFFFFD4, 32'hFD470F13};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 7'h0; rd = 5'h0; rs1 = 5'h0; rs2 = 5'h0; func3 = 3'h0; func7 = 7'h0; imm = 32'h0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // encode sweep with out_ready high
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_v(i);
        idle();
        drain();
        for (int i = 0; i < 6; i++) begin
            chk("sweep_word", log_q[i].w, sv[i].exp);
            chk("sweep_addr", log_q[i].a, 32'(4 * i));
        end

        // backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc0 = dut_acc;
        base = log_q.size();
        for (int i = 0; i < 4; i++) send_v(i);
        drive(sv[4].op, sv[4].d, sv[4].s1, sv[4].s2, sv[4].f3, sv[4].f7, sv[4].im);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_head", out_instr, 32'h00000713);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_acc();
        send_v(5);
        idle();
        drain();
        chk("bp_accepted", 32'(dut_acc - acc0), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("bp_order", log_q[base + i].w, sv[i].exp);
            chk("bp_addr", log_q[base + i].a, 32'(24 + 4 * i));
        end

        // illegal opcode between two legal addis
        ill0 = ill_cnt;
        base = log_q.size();
        send_v(1);
        send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0);
        send_v(1);
        idle();
        drain();
        chk("ill_pulses", 32'(ill_cnt - ill0), 32'd1);
        chk("ill_enqueued", 32'(log_q.size() - base), 32'd2);
        chk("ill_addr0", log_q[base].a, 32'h30);
        chk("ill_addr1", log_q[base + 1].a, 32'h34);
        // misaligned jal
        ill0 = ill_cnt;
        base = log_q.size();
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("jal_ill_pulses", 32'(ill_cnt - ill0), 32'd1);
        chk("jal_ill_enqueued", 32'(log_q.size() - base), 32'd0);

        // shift / U / J formats
        base = log_q.size();
        @(posedge clk); #1;
        send(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3);
        send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        idle();
        drain();
        chk("srai_word", log_q[base].w, 32'h40335293);
        chk("lui_word", log_q[base + 1].w, 32'h123450B7);
        chk("jal_word", log_q[base + 2].w, 32'h008000EF);
        chk("jal_addr", log_q[base + 2].a, 32'h40);

        // simultaneous push/pop at full
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = log_q.size();
        for (int i = 0; i < 4; i++) send_v(i);
        drive(sv[4].op, sv[4].d, sv[4].s1, sv[4].s2, sv[4].f3, sv[4].f7, sv[4].im);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("full_pop_count", 32'(count), 32'd3);
        wait_acc();
        send_v(5);
        for (int i = 0; i < 3; i++) send_v(i);
        idle();
        drain();
        chk("full_total", 32'(log_q.size() - base), 32'd9);
        for (int i = 0; i < 9; i++) chk("full_order", log_q[base + i].w, sv[i % 6].exp);

        // reset mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_v(i);
        drive(sv[3].op, sv[3].d, sv[3].s1, sv[3].s2, sv[3].f3, sv[3].f7, sv[3].im);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = log_q.size();
        send_v(1);
        idle();
        drain();
        chk("rst_addr", log_q[base].a, 32'h0);
        chk("rst_word", log_q[base].w, 32'h00a00613);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder: the inverse of the instruction decoder. It accepts decoded instruction fields (opcode, rd, rs1, rs2, func3, func7, imm) over a valid/ready handshake and packs them into a 32-bit instruction word tagged with a sequential word address. Results are buffered in a small FIFO and drained over a second valid/ready port. It feeds the instruction-memory loader and the decoder self-check bench, where encoded words are decoded and compared against the original fields.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of 2, at least 2.
- BASE_ADDR, 32'h0: address tagged onto the first legal instruction after reset.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  field bundle is valid.
- in_ready  out  1  encoder can accept; equals (count != FIFO_DEPTH).
- opcode  in  7  instruction opcode[6:0].
- rd, rs1, rs2  in  5 each  register indices.
- func3  in  3  funct3.
- func7  in  7  funct7; also supplies imm[11:5] for shift-immediates.
- imm  in  32  sign-extended immediate in decoder convention, with byte offsets for B/J and the upper 20 bits in imm[31:12] for U.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  32  address tag at the FIFO head.
- illegal  out  1  one-cycle pulse: the accepted bundle was rejected.
- count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

## Operation
- A bundle is accepted on a cycle with in_valid && in_ready. Accepted bundles are classified by opcode:
  - R (0110011): {func7, rs2, rs1, func3, rd, opcode}.
  - I (0010011, 0000011, 1100111, 1110011): {imm[11:0], rs1, func3, rd, opcode}.
  - Shift-immediate exception: opcode 0010011 with func3 001 or 101 encodes {func7, imm[4:0], rs1, func3, rd, opcode}.
  - S (0100011): {imm[11:5], rs2, rs1, func3, imm[4:0], rd-field replaced, opcode}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - U (0110111, 0010111): {imm[31:12], rd, opcode}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- An accepted bundle is illegal if any of the following holds:
  - the opcode is not listed above;
  - the opcode is B or J and imm[0] == 1.
- Illegal bundles are consumed: handshake completes, nothing is pushed, addr_ctr does not change, and illegal pulses high the next cycle.
- Legal bundles push {word, addr_ctr} into the FIFO, then addr_ctr += 4. addr_ctr is 32-bit and wraps from 32'hFFFFFFFC to 0 silently.
- Immediate bits not used by the selected format are ignored; no range checks are made.
- Pop occurs on out_valid && out_ready. A push and a pop in the same cycle leave count unchanged.
- When full, in_ready = 0, so no push is attempted. A pop in that cycle raises in_ready on the next cycle (no same-cycle pass-through).
- Reset (rst=1 at a clock edge), including mid-stream, has the following effects:
  - FIFO is flushed: count = 0, out_valid = 0.
  - addr_ctr = BASE_ADDR; illegal = 0.
  - out_instr and out_addr read 0.
  - in_ready is forced to 0 during the reset cycle and is 1 on the first cycle after reset.

## Timing
- Latency: a legal bundle accepted at edge N appears at the head with out_valid = 1 after edge N, provided the FIFO was empty. Behind k queued entries it waits for k pops.
- Throughput: 1 bundle/cycle in and 1 word/cycle out when out_ready is held high.
- out_instr and out_addr are held stable while out_valid && !out_ready.
- illegal is registered: high exactly one cycle, on the cycle after acceptance.
- All outputs are registered or derived from registered count/pointers only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- **Encode sweep, out_ready = 1.** Bundles:
  - addi x14,x0,0 → 32'h00000713;
  - addi x12,x0,10 → 32'h00a00613;
  - addi x13,x0,imm=32'hFFFFF801 → 32'h80100693;
  - add x14,x13,x14 → 32'h00e68733;
  - blt x13,x12,imm=-8 → 32'hFEC6CCE3;
  - addi x30,x14,-44 → 32'hFD470F13.

  Required: out_addr 0,4,8,…,20; each word 1 cycle after acceptance.
- **Backpressure.** Hold out_ready = 0 and offer 6 bundles. Required: in_ready drops after the 4th acceptance, count = 4, head stays 32'h00000713. Then raise out_ready: words drain in order, and accepted count reaches 6.
- **Illegal.** opcode 7'h7F between two legal addis. Required: a single illegal pulse; second addi gets address 4 (not 8); nothing enqueued for the bad bundle. Repeat with jal imm = 1 → illegal.
- **Shift/U/J formats.**
  - srai x5,x6,3 (func7 = 0100000) → 32'h40335293;
  - lui x1,imm=32'h12345000 → 32'h123450B7;
  - jal x1,imm=8 → 32'h008000EF.
- **Simultaneous push/pop at full.** Fill the FIFO, then assert out_ready while in_valid is held. Required: one pop occurs and count = 3, then push/pop alternate with count steady at 3 or 4, with no loss or duplication.
- **Reset mid-stream.** Assert rst with 3 entries queued and in_valid high. Required: next cycle count = 0, out_valid = 0, illegal = 0. The next legal bundle gets out_addr = BASE_ADDR.
